// File: rtl/vjtag_multi_dr.sv
// vjtag_multi_dr: virtual-JTAG multi-channel DR bank with length check, update strobes and TDO path.
// Define VJTAG_READBACK_EN to capture the selected channel into the shift register for readback.
module vjtag_multi_dr #(
  parameter int DR_WIDTH = 1024,
  parameter int NUM_CH = 4,
  parameter int IR_W = 3,
  parameter bit STRICT_LEN = 1
) (
  input  logic                         tck,
  input  logic                         aclr,
  input  logic                         tdi,
  input  logic [IR_W-1:0]              ir_in,
  input  logic                         v_cdr,
  input  logic                         v_sdr,
  input  logic                         v_udr,
  output logic                         tdo,
  output logic [NUM_CH*DR_WIDTH-1:0]   out_bus,
  output logic [NUM_CH-1:0]            upd_stb,
  output logic                         len_err
);
  localparam int CW = $clog2(DR_WIDTH + 2);
  localparam logic [IR_W-1:0] CH_MAX = IR_W'(NUM_CH);
  logic [DR_WIDTH-1:0] r_sr, w_cap;
  logic [CW-1:0] r_bit_cnt;
  logic r_bypass, r_udr_d, r_tdo, r_len_err;
  logic [NUM_CH*DR_WIDTH-1:0] r_out;
  logic [NUM_CH-1:0] r_upd;
  logic w_sel_valid, w_len_ok, w_upd_ev, w_commit, w_reject;
  logic [IR_W-1:0] w_ch;
  assign w_sel_valid = ir_in != '0 && ir_in <= CH_MAX;
  assign w_ch = ir_in - IR_W'(1);
  assign w_len_ok = !STRICT_LEN || r_bit_cnt == CW'(DR_WIDTH);
  assign w_upd_ev = v_udr && !r_udr_d && w_sel_valid;
  assign w_commit = w_upd_ev && w_len_ok;
  assign w_reject = w_upd_ev && !w_len_ok;
`ifdef VJTAG_READBACK_EN
  always_comb begin
    w_cap = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_sel_valid && w_ch == IR_W'(k)) w_cap = r_out[k*DR_WIDTH +: DR_WIDTH];
  end
`else
  assign w_cap = '0;
`endif
  always_ff @(posedge tck) begin
    if (aclr) begin
      r_sr <= '0;
      r_bit_cnt <= '0;
      r_bypass <= 1'b0;
      r_udr_d <= 1'b0;
      r_tdo <= 1'b0;
      r_out <= '0;
      r_upd <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_bypass <= tdi;
      r_udr_d <= v_udr;
      r_tdo <= w_sel_valid ? r_sr[DR_WIDTH-1] : r_bypass;
      if (v_cdr) begin
        r_sr <= w_cap;
        r_bit_cnt <= '0;
      end else if (v_sdr && w_sel_valid) begin
        r_sr <= {r_sr[DR_WIDTH-2:0], tdi};
        if (r_bit_cnt != CW'(DR_WIDTH + 1)) r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      if (w_commit) r_len_err <= 1'b0;
      else if (w_reject) r_len_err <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        r_upd[k] <= w_commit && w_ch == IR_W'(k);
        if (w_commit && w_ch == IR_W'(k)) r_out[k*DR_WIDTH +: DR_WIDTH] <= r_sr;
      end
    end
  end
  assign tdo = r_tdo;
  assign out_bus = r_out;
  assign upd_stb = r_upd;
  assign len_err = r_len_err;
endmodule

// File: tb/tb_vjtag_multi_dr.sv
// tb_vjtag_multi_dr: randomized scoreboard bench for vjtag_multi_dr against a bit-queue reference model.
module tb_vjtag_multi_dr;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic aclr = 1'b0, tdi = 1'b0, v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0;
  logic [2:0] ir_in = '0;
  logic tdo, len_err;
  logic [N*W-1:0] out_bus;
  logic [N-1:0] upd_stb;

  vjtag_multi_dr #(.DR_WIDTH(W), .NUM_CH(N), .IR_W(3), .STRICT_LEN(1'b1)) dut (
    .tck(clk), .aclr(aclr), .tdi(tdi), .ir_in(ir_in), .v_cdr(v_cdr), .v_sdr(v_sdr),
    .v_udr(v_udr), .tdo(tdo), .out_bus(out_bus), .upd_stb(upd_stb), .len_err(len_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    logic tdo;
    logic [N-1:0] upd;
    logic [N*W-1:0] bus;
    logic len;
  } exp_t;
  exp_t sbq[$];
  exp_t m_e;
  int n_chk = 0, n_pass = 0;

  // reference model: channel contents, bits held in the DR (front = next bit out), shifted count
  logic [W-1:0] m_mem[N];
  bit m_q[$];
  int m_cnt;
  logic m_len, m_udr, m_byp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
  endtask

  function automatic logic [N*W-1:0] bus_of();
    logic [N*W-1:0] b;
    for (int k = 0; k < N; k++) b[k*W +: W] = m_mem[k];
    return b;
  endfunction

  function automatic logic [W-1:0] word_of();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w = {w[W-2:0], m_q[i]};
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_mem[k] = '0;
    m_q = {};
    repeat (W) m_q.push_back(1'b0);
    m_cnt = 0;
    m_len = 1'b0;
    m_udr = 1'b0;
    m_byp = 1'b0;
  endtask

  task automatic step(input logic rst, input int ir, input logic cdr, input logic sdr,
                      input logic udr, input logic d);
    exp_t e;
    bit v;
    int ch;
    logic [W-1:0] cap = '0;
    logic [N-1:0] up = '0;
    logic t = 1'b0;
    aclr = rst; ir_in = ir[2:0]; v_cdr = cdr; v_sdr = sdr; v_udr = udr; tdi = d;
    if (rst) model_reset();
    else begin
      v = ir >= 1 && ir <= N;
      ch = ir - 1;
      t = v ? m_q[0] : m_byp;
`ifdef VJTAG_READBACK_EN
      if (v) cap = m_mem[ch];
`endif
      if (udr && !m_udr && v) begin
        if (m_cnt == W) begin
          m_mem[ch] = word_of();
          up[ch] = 1'b1;
          m_len = 1'b0;
        end else m_len = 1'b1;
      end
      if (cdr) begin
        m_q = {};
        for (int i = W - 1; i >= 0; i--) m_q.push_back(cap[i]);
        m_cnt = 0;
      end else if (sdr && v) begin
        void'(m_q.pop_front());
        m_q.push_back(d);
        if (m_cnt <= W) m_cnt++;
      end
      m_byp = d;
      m_udr = udr;
    end
    e.cyc = cyc + 1; e.tdo = t; e.upd = up; e.bus = bus_of(); e.len = m_len;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int ir_c, input int ir_u, input logic [W-1:0] data,
                      input int len, input int hold);
    logic b;
    step(1'b0, ir_c, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      b = 1'($urandom);
      if (i < W) b = data[W-1-i];
      step(1'b0, ir_c, 1'b0, 1'b1, 1'b0, b);
    end
    repeat (hold) step(1'b0, ir_u, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, ir_u, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      m_e = sbq.pop_front();
      chk("tdo", 32'(tdo), 32'(m_e.tdo));
      chk("upd_stb", 32'(upd_stb), 32'(m_e.upd));
      chk("out_bus", out_bus, m_e.bus);
      chk("len_err", 32'(len_err), 32'(m_e.len));
    end
  end

  initial begin
    logic [3:0] pat;
    int lens[5];
    model_reset();
    repeat (2) step(1'b1, int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    xfer(2, 2, 8'hA5, 8, 1);
    xfer(3, 3, 8'($urandom), 7, 3);
    xfer(3, 3, 8'h3C, 8, 1);
    pat = 4'b1011;
    for (int i = 3; i >= 0; i--) step(1'b0, 0, 1'b0, 1'b1, 1'b0, pat[i]);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(2, 2, 8'h00, 8, 1);
    step(1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 2, 1'b0, 1'b1, 1'b0, 1'($urandom));
    step(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    lens = '{7, 8, 8, 8, 9};
    repeat (60) begin
      int ir_c, ir_u;
      ir_c = int'($urandom_range(0, 7));
      ir_u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : ir_c;
      if ($urandom_range(0, 5) == 0)
        repeat (3) step(1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)), 1'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom));
      xfer(ir_c, ir_u, 8'($urandom), lens[$urandom_range(0, 4)], int'($urandom_range(1, 3)));
    end
    repeat (3) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected responses never checked", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vjtag_multi_dr.md
Name: vjtag_multi_dr

Overview:
- Parametrised multi-channel virtual-JTAG data-register bank, driven by the vJTAG megafunction's tck-domain state strobes.
- IR selects one of NUM_CH write channels, or bypass.
- Bits shift into a shared DR_WIDTH shift register and commit to the selected channel's output register on Update-DR, only when the shifted length is correct.
- Outputs feed the pattern-generation logic.
- Adds length checking, per-channel update strobes, a TDO path and optional readback.

Parameters:
- DR_WIDTH, 1024: bits per data register / output channel (>=2).
- NUM_CH, 4: number of write channels (1..2^IR_W-1).
- IR_W, 3: width of ir_in.
- STRICT_LEN, 1: 1 = commit only when exactly DR_WIDTH bits were shifted since Capture-DR; 0 = always commit.

Ports:
- tck  input  1  sole clock (JTAG TCK from vJTAG instance).
- aclr  input  1  reset, synchronous, active-high.
- tdi  input  1  serial data in.
- ir_in  input  IR_W  virtual instruction register.
- v_cdr  input  1  Capture-DR state strobe.
- v_sdr  input  1  Shift-DR state strobe.
- v_udr  input  1  Update-DR strobe.
- tdo  output  1  serial data out, registered.
- out_bus  output  NUM_CH*DR_WIDTH  channel k at bits [k*DR_WIDTH +: DR_WIDTH].
- upd_stb  output  NUM_CH  one-cycle pulse on the committed channel.
- len_err  output  1  last Update-DR rejected for wrong length.

Behaviour:
- All state updates on posedge tck. aclr takes priority over every other input.
- Reset values: sr=0, bit_cnt=0, bypass=0, udr_d=0, tdo=0, out_bus=0, upd_stb=0, len_err=0.
- Channel decode: sel_valid = (1 <= ir_in <= NUM_CH); ch = ir_in-1. Any other IR code, including 0, is bypass.
- Bypass register: bypass <= tdi every cycle.
- Capture-DR: when v_cdr is high, sr <= capture value (see Optional Feature) and bit_cnt <= 0. v_cdr beats v_sdr if both are high.
- Shift-DR: when v_sdr is high, v_cdr is low and sel_valid:
  - sr <= {sr[DR_WIDTH-2:0], tdi}.
  - bit_cnt increments, saturating at DR_WIDTH+1. bit_cnt is sized to hold DR_WIDTH+1.
  - With v_sdr high and !sel_valid, sr and bit_cnt hold.
- tdo register: tdo <= sel_valid ? sr[DR_WIDTH-1] : bypass. The MSB of sr shifts out first.
- Update-DR edge: udr_d <= v_udr; the update event is v_udr & !udr_d. A multi-cycle v_udr produces exactly one event.
- On an update event with sel_valid:
  - Commit when (!STRICT_LEN || bit_cnt == DR_WIDTH). Next cycle: out_bus channel ch <= sr, upd_stb[ch]=1 for exactly one cycle, len_err <= 0.
  - Otherwise out_bus holds, upd_stb stays 0, len_err <= 1.
- An update event with !sel_valid does nothing. len_err holds.
- len_err is sticky until the next successful commit or reset.
- upd_stb is 0 in every cycle that is not a commit cycle.
- Latency: out_bus and upd_stb change one cycle after the v_udr rising edge is sampled.
- Reset mid-shift: partial shift is discarded. A following update without a new Capture-DR fails the length check (STRICT_LEN=1).
- An IR change between Capture and Update commits into the channel selected at update time.

Optional Feature:
- Macro: VJTAG_READBACK_EN.
- Defined: on Capture-DR with sel_valid, sr <= current out_bus channel ch, so shifting returns the committed value on tdo, MSB first. Otherwise sr <= 0.
- Undefined: Capture-DR always loads sr <= 0. tdo then returns only the shifted-through data delayed DR_WIDTH cycles. There is no readback mux in the logic.

Test Plan (DR_WIDTH=8, NUM_CH=4, IR_W=3, STRICT_LEN=1):
1. Assert aclr 2 cycles with random strobes -> out_bus=0, upd_stb=0, len_err=0, tdo=0.
2. ir_in=2, pulse v_cdr, 8 v_sdr cycles of 0xA5 MSB-first, pulse v_udr -> out_bus[15:8]=0xA5; upd_stb=4'b0010 for one cycle; other channels 0; len_err=0.
3. ir_in=3, v_cdr, 7 shift cycles, then v_udr held 3 cycles -> out_bus unchanged, no upd_stb, len_err=1. Then a correct 8-bit write of 0x3C to ch2 -> out_bus[23:16]=0x3C, len_err=0, single upd_stb pulse.
4. ir_in=0, v_sdr high, tdi=1,0,1,1 -> tdo=1,0,1,1 lagging by 2 cycles; update event -> out_bus and upd_stb unchanged.
5. With VJTAG_READBACK_EN, ch1=0xA5: ir_in=2, v_cdr, shift 8 zeros -> tdo=1,0,1,0,0,1,0,1. Without the macro -> tdo all 0.
6. aclr after 4 of 8 shift bits, then v_udr -> out_bus stays 0, len_err=1, no upd_stb.
